// File: rtl/hex_scan_ctrl_if.sv
// hex_scan_ctrl_if
//   Load-side handshake between the application logic and hex_scan_ctrl.
//
//   load   : one-cycle strobe; captures value and lz_en into the pending buffer
//   value  : nibble i (bits 4i+3:4i) is the value for digit i
//   lz_en  : leading-zero suppression enable, captured together with value
//   ready  : 1 = no pending value is waiting for a frame boundary
//
//   master : application side (drives load/value/lz_en, observes ready)
//   slave  : scan controller side
interface hex_scan_ctrl_if #(
    parameter int DIGITS = 4
);
    logic                load;
    logic [4*DIGITS-1:0] value;
    logic                lz_en;
    logic                ready;

    modport master (output load, output value, output lz_en, input ready);
    modport slave  (input load, input value, input lz_en, output ready);
endinterface

// File: rtl/hex_scan_ctrl.sv
// hex_scan_ctrl
//   Time-multiplexes one shared 4-bit-to-7-segment decoder across DIGITS
//   common-anode digit positions. Each slot of TICK_DIV cycles selects one
//   digit; the first GUARD cycles of a slot deselect every digit to prevent
//   ghosting. New values arrive through a load handshake, sit in a pending
//   buffer and are copied to the display buffer only on a frame boundary.
//
//   Ports
//     clk        : system clock
//     rst_n      : asynchronous active-low reset
//     bus        : load handshake (load, value, lz_en in; ready out)
//     nibble     : value routed to the shared decoder for the selected digit
//     blank      : 1 = decoder output must be forced all-off
//     dig_sel_n  : one-hot active-low digit enable; all ones = none selected
//     frame_stb  : one-cycle pulse on the first cycle of each frame
module hex_scan_ctrl #(
    parameter int DIGITS   = 4,
    parameter int TICK_DIV = 50000,
    parameter int GUARD    = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    hex_scan_ctrl_if.slave    bus,
    output logic [3:0]        nibble,
    output logic              blank,
    output logic [DIGITS-1:0] dig_sel_n,
    output logic              frame_stb
);
    localparam int CNT_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam int VAL_W = 4 * DIGITS;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TICK_DIV - 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DIGITS - 1);

    // cnt/idx describe the slot position of the current cycle
    logic             started;
    logic [CNT_W-1:0] cnt;
    logic [IDX_W-1:0] idx;
    logic [VAL_W-1:0] disp;
    logic             disp_lz;
    logic             pend;
    logic [VAL_W-1:0] pend_val;
    logic             pend_lz;

    logic [CNT_W-1:0]  cnt_nxt;
    logic [IDX_W-1:0]  idx_nxt;
    logic [VAL_W-1:0]  disp_nxt;
    logic              disp_lz_nxt;
    logic              pend_nxt;
    logic              boundary;
    logic              in_guard;
    logic              frame_nxt;
    logic [3:0]        nib_nxt;
    logic              sup_nxt;
    logic [DIGITS-1:0] sel_nxt;
    logic [DIGITS-1:0] zero_from;

    // The first edge after reset release only arms the scanner, so the
    // cycle that follows it is the (cnt=0, idx=0) frame-start cycle with
    // its frame_stb already registered.
    always_comb begin
        cnt_nxt = cnt;
        idx_nxt = idx;
        if (started) begin
            if (cnt == CNT_LAST) begin
                cnt_nxt = '0;
                if (idx == IDX_LAST) begin
                    idx_nxt = '0;
                end else begin
                    idx_nxt = idx + 1'b1;
                end
            end else begin
                cnt_nxt = cnt + 1'b1;
            end
        end
    end

    assign boundary    = started && (cnt == '0) && (idx == '0);
    assign disp_nxt    = (boundary && pend) ? pend_val : disp;
    assign disp_lz_nxt = (boundary && pend) ? pend_lz  : disp_lz;
    // A load on the boundary cycle re-arms the pending flag for the next frame
    assign pend_nxt    = bus.load | (pend & ~boundary);
    assign frame_nxt   = (cnt_nxt == '0) && (idx_nxt == '0);
    assign bus.ready   = ~pend;

    generate
        if (GUARD > 0) begin : g_guard
            assign in_guard = (int'(cnt_nxt) < GUARD);
        end else begin : g_no_guard
            assign in_guard = 1'b0;
        end
    endgenerate

    // zero_from[i] = every display nibble from position i upwards is zero
    always_comb begin
        logic all_zero;
        all_zero  = 1'b1;
        zero_from = '0;
        for (int i = DIGITS - 1; i >= 0; i--) begin
            all_zero     = all_zero & (disp_nxt[4*i +: 4] == 4'h0);
            zero_from[i] = all_zero;
        end
    end

    // Outputs are registered from the next-cycle state so they line up
    // with the cnt/idx of the cycle in which they are visible.
    always_comb begin
        nib_nxt = 4'h0;
        sup_nxt = 1'b0;
        sel_nxt = '1;
        for (int i = 0; i < DIGITS; i++) begin
            if (idx_nxt == IDX_W'(i)) begin
                nib_nxt    = disp_nxt[4*i +: 4];
                sup_nxt    = disp_lz_nxt && (i != 0) && zero_from[i];
                sel_nxt[i] = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            started  <= 1'b0;
            cnt      <= '0;
            idx      <= '0;
            disp     <= '0;
            disp_lz  <= 1'b0;
            pend     <= 1'b0;
            pend_val <= '0;
            pend_lz  <= 1'b0;
        end else begin
            started <= 1'b1;
            cnt     <= cnt_nxt;
            idx     <= idx_nxt;
            disp    <= disp_nxt;
            disp_lz <= disp_lz_nxt;
            pend    <= pend_nxt;
            if (bus.load) begin
                pend_val <= bus.value;
                pend_lz  <= bus.lz_en;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            nibble    <= 4'h0;
            blank     <= 1'b1;
            dig_sel_n <= '1;
            frame_stb <= 1'b0;
        end else begin
            nibble    <= nib_nxt;
            frame_stb <= frame_nxt;
            if (in_guard) begin
                blank     <= 1'b1;
                dig_sel_n <= '1;
            end else begin
                blank     <= sup_nxt;
                dig_sel_n <= sel_nxt;
            end
        end
    end
endmodule

// File: tb/tb_hex_scan_ctrl.sv
// tb_hex_scan_ctrl
//   Self-checking bench for hex_scan_ctrl with DIGITS=4, TICK_DIV=8, GUARD=2.
//   Cycle n is the interval following the n-th rising edge after reset
//   release; the reference model derives slot position from n directly.
module tb_hex_scan_ctrl;
    localparam int DIGITS   = 4;
    localparam int TICK_DIV = 8;
    localparam int GUARD    = 2;
    localparam int FRAME    = DIGITS * TICK_DIV;

    logic              clk   = 1'b0;
    logic              rst_n = 1'b0;
    logic [3:0]        nibble;
    logic              blank;
    logic [DIGITS-1:0] dig_sel_n;
    logic              frame_stb;

    hex_scan_ctrl_if #(.DIGITS(DIGITS)) bus();

    hex_scan_ctrl #(
        .DIGITS   (DIGITS),
        .TICK_DIV (TICK_DIV),
        .GUARD    (GUARD)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .bus       (bus),
        .nibble    (nibble),
        .blank     (blank),
        .dig_sel_n (dig_sel_n),
        .frame_stb (frame_stb)
    );

    always #5 clk = ~clk;

    int tests    = 0;
    int failures = 0;
    int cyc      = 0;
    int curCyc   = 0;

    // Reference model: what the display should be holding
    logic [15:0] mDisp;
    logic        mLz;
    logic [15:0] mPendVal;
    logic        mPendLz;
    logic        mPend;

    typedef struct {
        logic [15:0] value;
        logic        lz;
        logic [3:0]  blankExp;
    } vec_t;

    vec_t vecs [8];

    task automatic checkOutput(input string name, input logic [15:0] act, input logic [15:0] exp);
        tests++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s at cycle %0d: got %h, expected %h", name, curCyc, act, exp);
        end
    endtask

    task automatic modelReset();
        mDisp    = 16'h0;
        mLz      = 1'b0;
        mPendVal = 16'h0;
        mPendLz  = 1'b0;
        mPend    = 1'b0;
    endtask

    // Compare every output against the model for the cycle curCyc
    task automatic checkModel();
        int          c;
        int          k;
        logic [15:0] sh;
        logic        sup;
        logic [3:0]  sel;
        c = curCyc % TICK_DIV;
        k = (curCyc / TICK_DIV) % DIGITS;
        checkOutput("frame_stb", 16'(frame_stb), 16'((c == 0) && (k == 0)));
        checkOutput("ready", 16'(bus.ready), 16'(!mPend));
        if (c < GUARD) begin
            checkOutput("guard_sel", 16'(dig_sel_n), 16'h000F);
            checkOutput("guard_blank", 16'(blank), 16'h0001);
        end else begin
            sh  = mDisp >> (4 * k);
            sup = mLz && (k != 0) && (sh == 16'h0);
            sel = ~(4'b0001 << k);
            checkOutput("dig_sel_n", 16'(dig_sel_n), 16'(sel));
            checkOutput("nibble", 16'(nibble), 16'(sh[3:0]));
            checkOutput("blank", 16'(blank), 16'(sup));
        end
    endtask

    task automatic modelEdge(input logic ld, input logic [15:0] val, input logic lz);
        logic frame;
        frame = (curCyc % FRAME) == 0;
        if (frame && mPend) begin
            mDisp = mPendVal;
            mLz   = mPendLz;
        end
        if (ld) begin
            mPendVal = val;
            mPendLz  = lz;
            mPend    = 1'b1;
        end else if (frame) begin
            mPend = 1'b0;
        end
    endtask

    // Drive inputs for cycle cyc, check outputs mid-cycle, advance the model
    task automatic applyStimulus(input logic ld, input logic [15:0] val, input logic lz);
        @(posedge clk);
        #1;
        bus.load  = ld;
        bus.value = val;
        bus.lz_en = lz;
        curCyc    = cyc;
        @(negedge clk);
        checkModel();
        modelEdge(ld, val, lz);
        cyc++;
    endtask

    task automatic idle();
        applyStimulus(1'b0, 16'h0, 1'b0);
    endtask

    task automatic idleUntil(input int target);
        while (cyc < target) idle();
    endtask

    task automatic idleUntilPhase(input int phase);
        while ((cyc % FRAME) != phase) idle();
    endtask

    task automatic applyReset();
        bus.load  = 1'b0;
        bus.value = 16'h0;
        bus.lz_en = 1'b0;
        rst_n     = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        curCyc = -1;
        checkOutput("rst_sel", 16'(dig_sel_n), 16'h000F);
        checkOutput("rst_blank", 16'(blank), 16'h0001);
        checkOutput("rst_ready", 16'(bus.ready), 16'h0001);
        checkOutput("rst_stb", 16'(frame_stb), 16'h0000);
        checkOutput("rst_nibble", 16'(nibble), 16'h0000);
        rst_n = 1'b1;
        modelReset();
        cyc = 0;
    endtask

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        int          b;
        logic        ld;
        logic [15:0] v;

        vecs[0] = '{16'h12AB, 1'b0, 4'b0000};
        vecs[1] = '{16'h0070, 1'b1, 4'b1100};
        vecs[2] = '{16'h0000, 1'b1, 4'b1110};
        vecs[3] = '{16'h0000, 1'b0, 4'b0000};
        vecs[4] = '{16'h0100, 1'b1, 4'b1000};
        vecs[5] = '{16'hF00F, 1'b1, 4'b0000};
        vecs[6] = '{16'h0A00, 1'b1, 4'b1000};
        vecs[7] = '{16'h000A, 1'b1, 4'b1110};

        // Idle scan after reset
        applyReset();
        idle();
        checkOutput("t1_stb_c0", 16'(frame_stb), 16'h0001);
        checkOutput("t1_sel_c0", 16'(dig_sel_n), 16'h000F);
        idleUntil(2);
        idle();
        checkOutput("t1_sel_c2", 16'(dig_sel_n), 16'h000E);
        checkOutput("t1_blank_c2", 16'(blank), 16'h0000);
        checkOutput("t1_nib_c2", 16'(nibble), 16'h0000);
        idleUntil(8);
        idle();
        checkOutput("t1_sel_c8", 16'(dig_sel_n), 16'h000F);
        idleUntil(10);
        idle();
        checkOutput("t1_sel_c10", 16'(dig_sel_n), 16'h000D);
        idleUntil(32);
        idle();
        checkOutput("t1_stb_c32", 16'(frame_stb), 16'h0001);
        idleUntil(64);

        // Load at cycle 5, takes effect at the cycle-32 boundary
        applyReset();
        idleUntil(5);
        applyStimulus(1'b1, 16'h12AB, 1'b0);
        idle();
        checkOutput("t2_ready_c6", 16'(bus.ready), 16'h0000);
        idleUntil(33);
        idle();
        checkOutput("t2_ready_c33", 16'(bus.ready), 16'h0001);
        idleUntil(36);
        idle();
        checkOutput("t2_nib_c36", 16'(nibble), 16'h000B);
        checkOutput("t2_sel_c36", 16'(dig_sel_n), 16'h000E);
        idleUntil(60);
        idle();
        checkOutput("t2_nib_c60", 16'(nibble), 16'h0001);
        checkOutput("t2_sel_c60", 16'(dig_sel_n), 16'h0007);
        idleUntil(64);

        // Table of values and their expected per-digit blanking
        for (int i = 0; i < 8; i++) begin
            idleUntilPhase(10);
            applyStimulus(1'b1, vecs[i].value, vecs[i].lz);
            idleUntilPhase(1);
            for (int k = 0; k < DIGITS; k++) begin
                idleUntilPhase(k * TICK_DIV + 4);
                idle();
                checkOutput("tbl_nibble", 16'(nibble), 16'(vecs[i].value[4*k +: 4]));
                checkOutput("tbl_blank", 16'(blank), 16'(vecs[i].blankExp[k]));
            end
        end

        // Latest load before the boundary wins
        idleUntilPhase(10);
        applyStimulus(1'b1, 16'h1111, 1'b0);
        idleUntilPhase(20);
        applyStimulus(1'b1, 16'h2222, 1'b0);
        idleUntilPhase(1);
        for (int j = 1; j < FRAME; j++) begin
            idle();
            if ((j % TICK_DIV) >= GUARD) begin
                checkOutput("t4_latest", 16'(nibble), 16'h0002);
            end
        end

        // Load on the boundary while another value is pending
        idleUntilPhase(10);
        applyStimulus(1'b1, 16'h5555, 1'b0);
        idleUntilPhase(0);
        b = cyc;
        applyStimulus(1'b1, 16'hAAAA, 1'b0);
        idle();
        checkOutput("t5_ready_b1", 16'(bus.ready), 16'h0000);
        idleUntil(b + 4);
        idle();
        checkOutput("t5_nib_5555", 16'(nibble), 16'h0005);
        idleUntil(b + 32);
        idle();
        checkOutput("t5_ready_b32", 16'(bus.ready), 16'h0000);
        idle();
        checkOutput("t5_ready_b33", 16'(bus.ready), 16'h0001);
        idleUntil(b + 36);
        idle();
        checkOutput("t5_nib_aaaa", 16'(nibble), 16'h000A);

        // Asynchronous reset mid-slot with a value pending
        applyReset();
        idleUntil(40);
        applyStimulus(1'b1, 16'h9999, 1'b1);
        idleUntil(45);
        idle();
        checkOutput("t6_sel_pre", 16'(dig_sel_n), 16'h000D);
        @(posedge clk);
        #3;
        bus.load = 1'b0;
        rst_n    = 1'b0;
        #1;
        curCyc = 46;
        checkOutput("t6_async_sel", 16'(dig_sel_n), 16'h000F);
        checkOutput("t6_async_blank", 16'(blank), 16'h0001);
        checkOutput("t6_async_ready", 16'(bus.ready), 16'h0001);
        applyReset();
        idleUntil(36);
        idle();
        checkOutput("t6_lost_nib", 16'(nibble), 16'h0000);
        checkOutput("t6_lost_ready", 16'(bus.ready), 16'h0001);
        idleUntil(70);

        // Random loads, nibbles biased towards zero to exercise suppression
        for (int n = 0; n < 800; n++) begin
            ld = ($urandom_range(0, 9) == 0);
            v  = 16'h0;
            for (int d = 0; d < DIGITS; d++) begin
                if ($urandom_range(0, 1) == 1) v[4*d +: 4] = 4'($urandom_range(0, 15));
            end
            applyStimulus(ld, v, 1'($urandom_range(0, 1)));
        end

        $display("[TB] %0d tests run, %0d failed", tests, failures);
        $finish;
    end
endmodule
